ftdi_fifo_emu: RTL and testbench
================================

Name: ftdi_fifo_emu

Overview:
- Synthesizable device-side model of the FT245-style FIFO interface: drives rxf_n/txe_n, responds to rd_n/wr_n, sources/sinks the data bus.
- Sits opposite ftdiController, inside the FPGA for loopback bring-up or in the bench as the pin-level responder.
- Holds an RX FIFO (host to controller reads) and a TX FIFO (controller writes to host), each with a valid/ready host port.

Parameters:
DEPTH_LOG2, 4, log2 of RX and TX FIFO depth (16 entries each)
RXF_RECOVERY, 2, cycles out_ftdi_rxf_n is held high after each completed read
TXE_RECOVERY, 2, cycles out_ftdi_txe_n is held high after each accepted write

Ports:
in_clk  in  1  single clock; all logic on rising edge
in_reset_n  in  1  asynchronous active-low reset
in_ftdi_rd_n  in  1  read strobe from controller, active low
in_ftdi_wr_n  in  1  write strobe from controller, active low
in_ftdi_data  in  8  bus value driven by controller
out_ftdi_data  out  8  bus value driven by this block
out_ftdi_data_oe  out  1  1 = this block drives the bus (tristate resolved by instantiator)
out_ftdi_rxf_n  out  1  low = RX data available
out_ftdi_txe_n  out  1  low = TX space available
in_host_data  in  8  byte to enqueue into RX FIFO
in_host_valid  in  1  push request
out_host_ready  out  1  RX FIFO not full
out_host_data  out  8  TX FIFO head
out_host_valid  out  1  TX FIFO not empty
in_host_ready  in  1  pop acknowledge
out_rx_count  out  DEPTH_LOG2+1  RX FIFO occupancy
out_tx_count  out  DEPTH_LOG2+1  TX FIFO occupancy
out_proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (async assert, sync release): FIFOs empty, counts 0, rxf_n=1, txe_n=1, data_oe=0, out_ftdi_data=0, host_ready=0 during reset then 1, host_valid=0, proto_err=0, strobe history registers=1.
- rd_n/wr_n are treated as synchronous to in_clk (no synchronizer); edges = current sample vs registered previous sample.
- FIFO: circular buffers, pointers DEPTH_LOG2+1 bits, wrap at 2^DEPTH_LOG2; full when count = 2^DEPTH_LOG2. Simultaneous push and pop on either FIFO are both honoured; count unchanged.
- Host RX push: in_host_valid && out_host_ready enqueues in_host_data; push while full is ignored.
- Host TX pop: out_host_valid && in_host_ready dequeues; out_host_data is the registered head, valid while out_host_valid=1.
- Read FSM R_IDLE / R_ACTIVE / R_RECOVER:
  - R_IDLE: rxf_n = (rx_count==0) registered, so rxf_n falls one cycle after first byte lands. rd_n falling edge with rxf_n=0 -> R_ACTIVE; next cycle data_oe=1, out_ftdi_data=RX head (one-cycle latency), held stable throughout R_ACTIVE.
  - rd_n falling edge with rxf_n=1 -> proto_err=1, no drive, no pop, stay R_IDLE.
  - R_ACTIVE: on rd_n rising edge, pop RX head, data_oe=0 same cycle, rxf_n=1 -> R_RECOVER.
  - R_RECOVER: rxf_n=1 for RXF_RECOVERY cycles, then R_IDLE.
- Write FSM W_IDLE / W_LOW / W_RECOVER:
  - W_IDLE: txe_n = (tx full) registered. wr_n falling edge with txe_n=0: capture in_ftdi_data that cycle, push to TX FIFO, txe_n=1 -> W_LOW.
  - wr_n falling edge with txe_n=1 -> proto_err=1, byte dropped.
  - W_LOW: wait for wr_n rising edge -> W_RECOVER.
  - W_RECOVER: txe_n=1 for TXE_RECOVERY cycles, then W_IDLE.
- Read and write FSMs are independent; concurrent rd_n and wr_n activity is legal.
- wr_n low while data_oe=1 (bus contention) -> proto_err=1; the write itself still follows the FSM rules.
- proto_err clears only on reset. Mid-operation reset aborts the transfer: no pop, no push, data_oe drops immediately.

Test Plan:
- Host pushes 0x11,0x22,0x33; controller issues three rd_n pulses (4 cycles low, 4 high) -> data_oe high with 0x11, 0x22, 0x33 in turn; rxf_n high 2 cycles after each pulse; rx_count 3->0.
- Controller writes 0xA5 then 0x5A via wr_n pulses -> out_host_valid=1, host pops 0xA5 then 0x5A; txe_n high for wr_n low time + 2 cycles per write.
- Controller writes 16 bytes without host pops -> tx_count=16, txe_n stays 1; 17th wr_n pulse -> proto_err=1, tx_count stays 16.
- rd_n pulse with RX empty -> data_oe stays 0, proto_err=1, rx_count stays 0.
- Host push and controller pop in the same cycle with rx_count=5 -> rx_count stays 5, byte order preserved across pointer wrap (push 20 bytes total).
- in_reset_n asserted while rd_n is low in R_ACTIVE -> data_oe=0 asynchronously; after release rxf_n=1, counts 0, proto_err=0.

Source files
------------

// File: rtl/ftdi_fifo_emu.sv
// ftdi_fifo_emu: device-side FT245-style FIFO responder.
// The host pushes bytes into the RX FIFO, and the controller drains them with rd_n pulses.
// The controller fills the TX FIFO with wr_n pulses, and the host drains it over a valid/ready port.
module ftdi_fifo_emu #(
  parameter int unsigned DEPTH_LOG2   = 4,
  parameter int unsigned RXF_RECOVERY = 2,
  parameter int unsigned TXE_RECOVERY = 2
) (
  input  logic                in_clk,
  input  logic                in_reset_n,
  input  logic                in_ftdi_rd_n,
  input  logic                in_ftdi_wr_n,
  input  logic [7:0]          in_ftdi_data,
  output logic [7:0]          out_ftdi_data,
  output logic                out_ftdi_data_oe,
  output logic                out_ftdi_rxf_n,
  output logic                out_ftdi_txe_n,
  input  logic [7:0]          in_host_data,
  input  logic                in_host_valid,
  output logic                out_host_ready,
  output logic [7:0]          out_host_data,
  output logic                out_host_valid,
  input  logic                in_host_ready,
  output logic [DEPTH_LOG2:0] out_rx_count,
  output logic [DEPTH_LOG2:0] out_tx_count,
  output logic                out_proto_err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] FULL     = PW'(DEPTH);
  localparam logic [7:0]    RXF_LAST = 8'(RXF_RECOVERY - 1);
  localparam logic [7:0]    TXE_LAST = 8'(TXE_RECOVERY - 1);

  typedef enum logic [1:0] {R_IDLE, R_ACTIVE, R_RECOVER} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_LOW, W_RECOVER} wstate_t;

  // FIFO storage and pointers
  logic [7:0]    rx_mem [DEPTH];
  logic [7:0]    tx_mem [DEPTH];
  logic [PW-1:0] rx_wptr, rx_rptr, tx_wptr, tx_rptr;
  logic [PW-1:0] rx_count, tx_count;
  logic          rx_push, rx_pop, tx_push, tx_pop;
  logic          alive;

  // Strobe history and edge detection
  logic rd_prev, wr_prev;
  logic rd_fall, rd_rise, wr_fall, wr_rise;

  // Read side
  rstate_t    rstate, rstate_nxt;
  logic       rxf_n, rxf_n_nxt;
  logic       oe, oe_nxt;
  logic [7:0] rdata, rdata_nxt;
  logic [7:0] rcnt, rcnt_nxt;
  logic       rd_err;

  // Write side
  wstate_t    wstate, wstate_nxt;
  logic       txe_n, txe_n_nxt;
  logic [7:0] wcnt, wcnt_nxt;
  logic       wr_err;

  logic proto_err;

  assign rx_count = rx_wptr - rx_rptr;
  assign tx_count = tx_wptr - tx_rptr;

  assign rd_fall = rd_prev && !in_ftdi_rd_n;
  assign rd_rise = !rd_prev && in_ftdi_rd_n;
  assign wr_fall = wr_prev && !in_ftdi_wr_n;
  assign wr_rise = !wr_prev && in_ftdi_wr_n;

  assign out_host_ready = alive && (rx_count != FULL);
  assign rx_push        = in_host_valid && out_host_ready;
  assign out_host_valid = (tx_count != '0);
  assign tx_pop         = out_host_valid && in_host_ready;
  assign out_host_data  = tx_mem[tx_rptr[DEPTH_LOG2-1:0]];

  assign out_ftdi_data    = rdata;
  assign out_ftdi_data_oe = oe;
  assign out_ftdi_rxf_n   = rxf_n;
  assign out_ftdi_txe_n   = txe_n;
  assign out_rx_count     = rx_count;
  assign out_tx_count     = tx_count;
  assign out_proto_err    = proto_err;

  // FIFO storage writes (no reset needed; pointers define validity)
  always_ff @(posedge in_clk) begin
    if (rx_push) rx_mem[rx_wptr[DEPTH_LOG2-1:0]] <= in_host_data;
    if (tx_push) tx_mem[tx_wptr[DEPTH_LOG2-1:0]] <= in_ftdi_data;
  end

  // FIFO pointers, host-ready enable and strobe history
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      rx_wptr <= '0;
      rx_rptr <= '0;
      tx_wptr <= '0;
      tx_rptr <= '0;
      alive   <= 1'b0;
      rd_prev <= 1'b1;
      wr_prev <= 1'b1;
    end else begin
      alive   <= 1'b1;
      rd_prev <= in_ftdi_rd_n;
      wr_prev <= in_ftdi_wr_n;
      if (rx_push) rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
      if (tx_push) tx_wptr <= tx_wptr + 1'b1;
      if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
    end
  end

  // Read FSM next state and registered bus outputs
  always_comb begin
    rstate_nxt = rstate;
    rxf_n_nxt  = rxf_n;
    oe_nxt     = oe;
    rdata_nxt  = rdata;
    rcnt_nxt   = rcnt;
    rx_pop     = 1'b0;
    rd_err     = rd_fall && rxf_n;
    case (rstate)
      R_IDLE: begin
        rxf_n_nxt = (rx_count == '0);
        if (rd_fall && !rxf_n) begin
          rstate_nxt = R_ACTIVE;
          rxf_n_nxt  = 1'b0;
          oe_nxt     = 1'b1;
          rdata_nxt  = rx_mem[rx_rptr[DEPTH_LOG2-1:0]];
        end
      end
      R_ACTIVE: begin
        if (rd_rise) begin
          rstate_nxt = R_RECOVER;
          rx_pop     = 1'b1;
          oe_nxt     = 1'b0;
          rxf_n_nxt  = 1'b1;
          rcnt_nxt   = '0;
        end
      end
      R_RECOVER: begin
        // The last recovery cycle already reloads rxf_n so it is high for exactly RXF_RECOVERY cycles
        if (rcnt == RXF_LAST) begin
          rstate_nxt = R_IDLE;
          rxf_n_nxt  = (rx_count == '0);
        end else begin
          rcnt_nxt = rcnt + 8'd1;
        end
      end
      default: rstate_nxt = R_IDLE;
    endcase
  end

  // Read FSM state register
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      rstate <= R_IDLE;
      rxf_n  <= 1'b1;
      oe     <= 1'b0;
      rdata  <= '0;
      rcnt   <= '0;
    end else begin
      rstate <= rstate_nxt;
      rxf_n  <= rxf_n_nxt;
      oe     <= oe_nxt;
      rdata  <= rdata_nxt;
      rcnt   <= rcnt_nxt;
    end
  end

  // Write FSM next state; the byte is captured on the same cycle as the falling edge
  always_comb begin
    wstate_nxt = wstate;
    txe_n_nxt  = txe_n;
    wcnt_nxt   = wcnt;
    tx_push    = 1'b0;
    wr_err     = wr_fall && txe_n;
    case (wstate)
      W_IDLE: begin
        txe_n_nxt = (tx_count == FULL);
        if (wr_fall && !txe_n) begin
          wstate_nxt = W_LOW;
          tx_push    = (tx_count != FULL);
          txe_n_nxt  = 1'b1;
        end
      end
      W_LOW: begin
        if (wr_rise) begin
          wstate_nxt = W_RECOVER;
          wcnt_nxt   = '0;
        end
      end
      W_RECOVER: begin
        if (wcnt == TXE_LAST) begin
          wstate_nxt = W_IDLE;
          txe_n_nxt  = (tx_count == FULL);
        end else begin
          wcnt_nxt = wcnt + 8'd1;
        end
      end
      default: wstate_nxt = W_IDLE;
    endcase
  end

  // Write FSM state register
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      wstate <= W_IDLE;
      txe_n  <= 1'b1;
      wcnt   <= '0;
    end else begin
      wstate <= wstate_nxt;
      txe_n  <= txe_n_nxt;
      wcnt   <= wcnt_nxt;
    end
  end

  // Sticky protocol error: bad strobes or a write while this block drives the bus
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      proto_err <= 1'b0;
    end else if (rd_err || wr_err || (!in_ftdi_wr_n && oe)) begin
      proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ftdi_fifo_emu.sv
// tb_ftdi_fifo_emu: table vectors, directed corner sequences and random traffic against a queue model.
module tb_ftdi_fifo_emu;

  localparam int D = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rd_n = 1'b1;
  logic       wr_n = 1'b1;
  logic [7:0] fdin = '0;
  logic [7:0] fdout;
  logic       oe, rxf_n, txe_n;
  logic [7:0] hdin = '0;
  logic       hvalid_in = 1'b0;
  logic       hready_out;
  logic [7:0] hdout;
  logic       hvalid_out;
  logic       hready_in = 1'b0;
  logic [4:0] rx_count, tx_count;
  logic       err;

  int total = 0;
  int bad = 0;

  typedef enum int {OP_PUSH, OP_POP, OP_READ, OP_WRITE, OP_RDEMPTY} op_t;
  typedef struct {
    op_t        op;
    logic [7:0] arg;
    int         len;
    bit         cg;
    logic [7:0] eg;
    int         eaux;
    int         erx;
    int         etx;
    bit         eerr;
  } vec_t;

  always #5 clk = ~clk;

  ftdi_fifo_emu #(.DEPTH_LOG2(4), .RXF_RECOVERY(2), .TXE_RECOVERY(2)) dut (
    .in_clk           (clk),
    .in_reset_n       (rst_n),
    .in_ftdi_rd_n     (rd_n),
    .in_ftdi_wr_n     (wr_n),
    .in_ftdi_data     (fdin),
    .out_ftdi_data    (fdout),
    .out_ftdi_data_oe (oe),
    .out_ftdi_rxf_n   (rxf_n),
    .out_ftdi_txe_n   (txe_n),
    .in_host_data     (hdin),
    .in_host_valid    (hvalid_in),
    .out_host_ready   (hready_out),
    .out_host_data    (hdout),
    .out_host_valid   (hvalid_out),
    .in_host_ready    (hready_in),
    .out_rx_count     (rx_count),
    .out_tx_count     (tx_count),
    .out_proto_err    (err)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rd_n = 1'b1;
    wr_n = 1'b1;
    hvalid_in = 1'b0;
    hready_in = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  // One complete transaction; got/aux/ok meaning depends on op
  task automatic do_op(input op_t op, input logic [7:0] arg, input int len,
                       input bit co_push, input logic [7:0] co_byte,
                       output logic [7:0] got, output int aux, output bit ok);
    bit run;
    got = '0;
    aux = 0;
    ok = 1'b1;
    run = 1'b1;
    case (op)
      OP_PUSH: begin
        aux = int'(hready_out);
        hdin = arg;
        hvalid_in = 1'b1;
        tick();
        hvalid_in = 1'b0;
        tick();
      end
      OP_POP: begin
        aux = int'(hvalid_out);
        got = hdout;
        hready_in = 1'b1;
        tick();
        hready_in = 1'b0;
        tick();
      end
      OP_READ: begin
        rd_n = 1'b0;
        for (int i = 0; i < len; i++) begin
          tick();
          if (i == 0) got = fdout;
          if (oe !== 1'b1 || fdout !== got) ok = 1'b0;
        end
        rd_n = 1'b1;
        if (co_push) begin
          hdin = co_byte;
          hvalid_in = 1'b1;
        end
        for (int i = 0; i < 6; i++) begin
          tick();
          hvalid_in = 1'b0;
          if (i == 0 && oe !== 1'b0) ok = 1'b0;
          if (run && rxf_n === 1'b1) aux++; else run = 1'b0;
        end
      end
      OP_WRITE: begin
        wr_n = 1'b0;
        fdin = arg;
        for (int i = 0; i < len; i++) begin
          tick();
          fdin = ~arg;
          if (run && txe_n === 1'b1) aux++; else run = 1'b0;
        end
        wr_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
          tick();
          if (run && txe_n === 1'b1) aux++; else run = 1'b0;
        end
      end
      default: begin
        rd_n = 1'b0;
        for (int i = 0; i < len; i++) begin
          tick();
          if (oe !== 1'b0) got = 8'd1;
        end
        rd_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
          tick();
          if (oe !== 1'b0) got = 8'd1;
          if (run && rxf_n === 1'b1) aux++; else run = 1'b0;
        end
      end
    endcase
  endtask

  initial begin
    vec_t       vec [12];
    logic [7:0] rxq [$];
    logic [7:0] txq [$];
    logic [7:0] got, b, eb;
    int         aux, r, k, len, eaux;
    bit         ok, ev;

    vec[0]  = '{OP_PUSH,    8'h11, 0, 1'b0, 8'h00, 1, 1, 0, 1'b0};
    vec[1]  = '{OP_PUSH,    8'h22, 0, 1'b0, 8'h00, 1, 2, 0, 1'b0};
    vec[2]  = '{OP_PUSH,    8'h33, 0, 1'b0, 8'h00, 1, 3, 0, 1'b0};
    vec[3]  = '{OP_READ,    8'h00, 4, 1'b1, 8'h11, 2, 2, 0, 1'b0};
    vec[4]  = '{OP_READ,    8'h00, 4, 1'b1, 8'h22, 2, 1, 0, 1'b0};
    vec[5]  = '{OP_READ,    8'h00, 4, 1'b1, 8'h33, 6, 0, 0, 1'b0};
    vec[6]  = '{OP_WRITE,   8'hA5, 4, 1'b0, 8'h00, 6, 0, 1, 1'b0};
    vec[7]  = '{OP_WRITE,   8'h5A, 4, 1'b0, 8'h00, 6, 0, 2, 1'b0};
    vec[8]  = '{OP_POP,     8'h00, 0, 1'b1, 8'hA5, 1, 0, 1, 1'b0};
    vec[9]  = '{OP_POP,     8'h00, 0, 1'b1, 8'h5A, 1, 0, 0, 1'b0};
    vec[10] = '{OP_POP,     8'h00, 0, 1'b0, 8'h00, 0, 0, 0, 1'b0};
    vec[11] = '{OP_RDEMPTY, 8'h00, 4, 1'b1, 8'h00, 6, 0, 0, 1'b1};

    // Reset values while reset is still asserted
    tick();
    chk("rst_rxf_n", 32'(rxf_n), 32'd1);
    chk("rst_txe_n", 32'(txe_n), 32'd1);
    chk("rst_oe", 32'(oe), 32'd0);
    chk("rst_data", 32'(fdout), 32'd0);
    chk("rst_host_ready", 32'(hready_out), 32'd0);
    chk("rst_host_valid", 32'(hvalid_out), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rx_count", 32'(rx_count), 32'd0);
    chk("rst_tx_count", 32'(tx_count), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_host_ready", 32'(hready_out), 32'd1);
    chk("post_rst_txe_n", 32'(txe_n), 32'd0);

    // Table vectors
    for (int i = 0; i < 12; i++) begin
      do_op(vec[i].op, vec[i].arg, vec[i].len, 1'b0, 8'h00, got, aux, ok);
      if (vec[i].cg) chk($sformatf("vec%0d_data", i), 32'(got), 32'(vec[i].eg));
      chk($sformatf("vec%0d_aux", i), 32'(aux), 32'(vec[i].eaux));
      if (vec[i].op == OP_READ) chk($sformatf("vec%0d_drive", i), 32'(ok), 32'd1);
      chk($sformatf("vec%0d_rx", i), 32'(rx_count), 32'(vec[i].erx));
      chk($sformatf("vec%0d_tx", i), 32'(tx_count), 32'(vec[i].etx));
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(vec[i].eerr));
    end

    // TX fill to full, then one write too many
    do_reset();
    for (int i = 0; i < D; i++) begin
      do_op(OP_WRITE, 8'(8'h30 + i), 2, 1'b0, 8'h00, got, aux, ok);
      chk($sformatf("fill%0d_tx", i), 32'(tx_count), 32'(i + 1));
      chk($sformatf("fill%0d_txe", i), 32'(aux), (i < D - 1) ? 32'd4 : 32'd7);
    end
    chk("full_txe_n", 32'(txe_n), 32'd1);
    chk("full_err_before", 32'(err), 32'd0);
    do_op(OP_WRITE, 8'hEE, 2, 1'b0, 8'h00, got, aux, ok);
    chk("over_err", 32'(err), 32'd1);
    chk("over_tx", 32'(tx_count), 32'd16);
    for (int i = 0; i < D; i++) begin
      do_op(OP_POP, 8'h00, 0, 1'b0, 8'h00, got, aux, ok);
      chk($sformatf("drain%0d_data", i), 32'(got), 32'(8'h30 + i));
    end
    chk("drain_tx", 32'(tx_count), 32'd0);

    // RX wrap with simultaneous host push and controller pop
    do_reset();
    for (int i = 0; i < 5; i++) do_op(OP_PUSH, 8'(8'h40 + i), 0, 1'b0, 8'h00, got, aux, ok);
    chk("wrap_pre_rx", 32'(rx_count), 32'd5);
    for (int i = 0; i < 20; i++) begin
      do_op(OP_READ, 8'h00, 2, (i < 15), 8'(8'h45 + i), got, aux, ok);
      chk($sformatf("wrap%0d_data", i), 32'(got), 32'(8'h40 + i));
      chk($sformatf("wrap%0d_rx", i), 32'(rx_count), (i < 15) ? 32'd5 : 32'(19 - i));
      chk($sformatf("wrap%0d_rxf", i), 32'(aux), (i < 19) ? 32'd2 : 32'd6);
    end

    // Random traffic against queue model
    for (int n = 0; n < 250; n++) begin
      r = int'($urandom_range(0, 9));
      len = int'($urandom_range(1, 5));
      b = 8'($urandom);
      k = (r <= 3) ? 0 : (r <= 5) ? 1 : (r <= 7) ? 2 : 3;
      if (k == 2 && rxq.size() == 0) k = 0;
      if (k == 3 && txq.size() == D) k = 1;
      case (k)
        0: begin
          ev = (rxq.size() < D);
          do_op(OP_PUSH, b, 0, 1'b0, 8'h00, got, aux, ok);
          chk("rnd_ready", 32'(aux), 32'(ev));
          if (ev) rxq.push_back(b);
        end
        1: begin
          ev = (txq.size() > 0);
          do_op(OP_POP, 8'h00, 0, 1'b0, 8'h00, got, aux, ok);
          chk("rnd_valid", 32'(aux), 32'(ev));
          if (ev) begin
            eb = txq.pop_front();
            chk("rnd_pop_data", 32'(got), 32'(eb));
          end
        end
        2: begin
          eb = rxq.pop_front();
          eaux = (rxq.size() > 0) ? 2 : 6;
          do_op(OP_READ, 8'h00, len, 1'b0, 8'h00, got, aux, ok);
          chk("rnd_read_data", 32'(got), 32'(eb));
          chk("rnd_read_drive", 32'(ok), 32'd1);
          chk("rnd_read_rxf", 32'(aux), 32'(eaux));
        end
        default: begin
          txq.push_back(b);
          eaux = (txq.size() < D) ? len + 2 : len + 5;
          do_op(OP_WRITE, b, len, 1'b0, 8'h00, got, aux, ok);
          chk("rnd_write_txe", 32'(aux), 32'(eaux));
        end
      endcase
      chk("rnd_rx_count", 32'(rx_count), 32'(rxq.size()));
      chk("rnd_tx_count", 32'(tx_count), 32'(txq.size()));
      chk("rnd_err", 32'(err), 32'd0);
    end

    // Write while this block drives the bus
    do_reset();
    do_op(OP_PUSH, 8'h66, 0, 1'b0, 8'h00, got, aux, ok);
    rd_n = 1'b0;
    tick();
    chk("cont_oe", 32'(oe), 32'd1);
    wr_n = 1'b0;
    fdin = 8'h99;
    tick();
    wr_n = 1'b1;
    fdin = 8'h00;
    tick();
    chk("cont_err", 32'(err), 32'd1);
    rd_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("cont_rx", 32'(rx_count), 32'd0);
    chk("cont_tx", 32'(tx_count), 32'd1);
    do_op(OP_POP, 8'h00, 0, 1'b0, 8'h00, got, aux, ok);
    chk("cont_pop_data", 32'(got), 32'h99);

    // Reset in the middle of an active read
    do_reset();
    do_op(OP_PUSH, 8'h77, 0, 1'b0, 8'h00, got, aux, ok);
    rd_n = 1'b0;
    tick();
    tick();
    chk("midrst_oe_before", 32'(oe), 32'd1);
    chk("midrst_data", 32'(fdout), 32'h77);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_oe_async", 32'(oe), 32'd0);
    rd_n = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("midrst_rxf_n", 32'(rxf_n), 32'd1);
    chk("midrst_rx", 32'(rx_count), 32'd0);
    chk("midrst_tx", 32'(tx_count), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_oe_after", 32'(oe), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
